// File: rtl/id_decode_stage.sv
// Registered RV32I instruction-decode stage between fetch and execute.
// Decodes the raw word combinationally and captures every field in a single
// output register stage. Valid/ready handshakes on both sides decouple
// fetch and execute. One bubble is inserted per load-use pair. A flush
// empties the stage. Inserted bubbles are counted in a saturating counter.
module id_decode_stage #(
    parameter int unsigned BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [31:0]             in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             pc,
    output logic [6:0]              opcode,
    output logic [4:0]              rd,
    output logic [2:0]              funct3,
    output logic [4:0]              rs1,
    output logic [4:0]              rs2,
    output logic [6:0]              funct7,
    output logic [11:0]             imm_i,
    output logic [11:0]             imm_s,
    output logic [11:0]             imm_b,
    output logic [20:0]             imm_j,
    output logic [19:0]             imm_u,
    output logic [31:0]             imm32,
    output logic                    illegal,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    // RV32I base opcodes recognised by this stage
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // ------------------------------------------------------------------
    // Combinational field extraction from the incoming word
    // ------------------------------------------------------------------
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_funct3;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [6:0]  dec_funct7;
    logic [11:0] dec_imm_i;
    logic [11:0] dec_imm_s;
    logic [11:0] dec_imm_b;
    logic [20:0] dec_imm_j;
    logic [19:0] dec_imm_u;
    logic [31:0] dec_imm32;
    logic        dec_illegal;
    logic        dec_use_rs1;
    logic        dec_use_rs2;

    assign dec_opcode = in_instr[6:0];
    assign dec_rd     = in_instr[11:7];
    assign dec_funct3 = in_instr[14:12];
    assign dec_rs1    = in_instr[19:15];
    assign dec_rs2    = in_instr[24:20];
    assign dec_funct7 = in_instr[31:25];
    assign dec_imm_i  = in_instr[31:20];
    assign dec_imm_s  = {in_instr[31:25], in_instr[11:7]};
    // imm_b holds offset bits [12:1]; bit 0 is implicitly zero
    assign dec_imm_b  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
    assign dec_imm_j  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign dec_imm_u  = in_instr[31:12];

    // Select the ALU immediate and the register sources the format reads
    always_comb begin
        dec_imm32   = 32'd0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        unique case (dec_opcode)
            OpImm, OpLoad, OpJalr: begin
                dec_imm32   = {{20{dec_imm_i[11]}}, dec_imm_i};
                dec_use_rs1 = 1'b1;
            end
            OpStore: begin
                dec_imm32   = {{20{dec_imm_s[11]}}, dec_imm_s};
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            OpBranch: begin
                dec_imm32   = {{19{dec_imm_b[11]}}, dec_imm_b, 1'b0};
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            OpJal: begin
                dec_imm32 = {{11{dec_imm_j[20]}}, dec_imm_j};
            end
            OpLui, OpAuipc: begin
                dec_imm32 = {dec_imm_u, 12'd0};
            end
            OpReg: begin
                // R-type carries no immediate; expose the shamt/rs2 slot
                dec_imm32   = {27'd0, dec_rs2};
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            default: begin
                dec_imm32 = 32'd0;
            end
        endcase
    end

    // Flag encodings outside the supported RV32I subset
    always_comb begin
        dec_illegal = 1'b0;
        unique case (dec_opcode)
            OpLoad: begin
                dec_illegal = (dec_funct3 == 3'b011) || (dec_funct3 == 3'b110) ||
                              (dec_funct3 == 3'b111);
            end
            OpStore: begin
                dec_illegal = (dec_funct3 > 3'b010);
            end
            OpBranch: begin
                dec_illegal = (dec_funct3 == 3'b010) || (dec_funct3 == 3'b011);
            end
            OpJalr: begin
                dec_illegal = (dec_funct3 != 3'b000);
            end
            OpReg: begin
                if (dec_funct7 == F7Zero) begin
                    dec_illegal = 1'b0;
                end else if (dec_funct7 == F7Alt) begin
                    // Only SUB and SRA use the alternate funct7
                    dec_illegal = (dec_funct3 != 3'b000) && (dec_funct3 != 3'b101);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpImm: begin
                if (dec_funct3 == 3'b001) begin
                    dec_illegal = (dec_funct7 != F7Zero);
                end else if (dec_funct3 == 3'b101) begin
                    dec_illegal = (dec_funct7 != F7Zero) && (dec_funct7 != F7Alt);
                end else begin
                    dec_illegal = 1'b0;
                end
            end
            OpLui, OpAuipc, OpJal: begin
                dec_illegal = 1'b0;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic                    out_valid_q;
    logic [31:0]             pc_q;
    logic [6:0]              opcode_q;
    logic [4:0]              rd_q;
    logic [2:0]              funct3_q;
    logic [4:0]              rs1_q;
    logic [4:0]              rs2_q;
    logic [6:0]              funct7_q;
    logic [11:0]             imm_i_q;
    logic [11:0]             imm_s_q;
    logic [11:0]             imm_b_q;
    logic [20:0]             imm_j_q;
    logic [19:0]             imm_u_q;
    logic [31:0]             imm32_q;
    logic                    illegal_q;
    logic [BUBBLE_CNT_W-1:0] bubble_count_q;

    logic held_load;
    logic src_hit;
    logic hazard;
    logic accept;
    logic bubble_inc;

    // A held load with a non-zero destination can feed the next instruction
    assign held_load  = out_valid_q && (opcode_q == OpLoad) && (rd_q != 5'd0);
    assign src_hit    = (dec_use_rs1 && (dec_rs1 == rd_q)) || (dec_use_rs2 && (dec_rs2 == rd_q));
    assign hazard     = in_valid && held_load && src_hit;
    assign in_ready   = rst_n && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    // The stalled consumer stays upstream while the load drains: one bubble
    assign bubble_inc = hazard && out_ready && !flush;

    // Pipeline register: flush beats accept, accept beats drain, else hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            pc_q        <= 32'd0;
            opcode_q    <= 7'd0;
            rd_q        <= 5'd0;
            funct3_q    <= 3'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            funct7_q    <= 7'd0;
            imm_i_q     <= 12'd0;
            imm_s_q     <= 12'd0;
            imm_b_q     <= 12'd0;
            imm_j_q     <= 21'd0;
            imm_u_q     <= 20'd0;
            imm32_q     <= 32'd0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            pc_q        <= in_pc;
            opcode_q    <= dec_opcode;
            rd_q        <= dec_rd;
            funct3_q    <= dec_funct3;
            rs1_q       <= dec_rs1;
            rs2_q       <= dec_rs2;
            funct7_q    <= dec_funct7;
            imm_i_q     <= dec_imm_i;
            imm_s_q     <= dec_imm_s;
            imm_b_q     <= dec_imm_b;
            imm_j_q     <= dec_imm_j;
            imm_u_q     <= dec_imm_u;
            imm32_q     <= dec_imm32;
            illegal_q   <= dec_illegal;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Saturating count of load-use bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_count_q <= '0;
        end else if (bubble_inc && (bubble_count_q != {BUBBLE_CNT_W{1'b1}})) begin
            bubble_count_q <= bubble_count_q + BUBBLE_CNT_W'(1);
        end
    end

    assign out_valid    = out_valid_q;
    assign pc           = pc_q;
    assign opcode       = opcode_q;
    assign rd           = rd_q;
    assign funct3       = funct3_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign funct7       = funct7_q;
    assign imm_i        = imm_i_q;
    assign imm_s        = imm_s_q;
    assign imm_b        = imm_b_q;
    assign imm_j        = imm_j_q;
    assign imm_u        = imm_u_q;
    assign imm32        = imm32_q;
    assign illegal      = illegal_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed test-plan cases followed by
// randomized traffic, checked against a behavioural decode/occupancy model.
module tb_id_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [11:0] imm_i;
        logic [11:0] imm_s;
        logic [11:0] imm_b;
        logic [20:0] imm_j;
        logic [19:0] imm_u;
        logic [31:0] imm32;
        logic        illegal;
    } dec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [11:0] imm_b;
    logic [20:0] imm_j;
    logic [19:0] imm_u;
    logic [31:0] imm32;
    logic        illegal;
    logic [15:0] bubble_count;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model state: expected outputs queued in issue order
    dec_t        sb[$];
    bit          m_valid = 1'b0;
    logic [31:0] m_held  = 32'd0;
    logic [15:0] m_cnt   = 16'd0;

    id_decode_stage #(.BUBBLE_CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pc           (pc),
        .opcode       (opcode),
        .rd           (rd),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct7       (funct7),
        .imm_i        (imm_i),
        .imm_s        (imm_s),
        .imm_b        (imm_b),
        .imm_j        (imm_j),
        .imm_u        (imm_u),
        .imm32        (imm32),
        .illegal      (illegal),
        .bubble_count (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h03:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            7'h23:   return f3 inside {3'd0, 3'd1, 3'd2};
            7'h63:   return !(f3 inside {3'd2, 3'd3});
            7'h67:   return f3 == 3'd0;
            7'h33:   return (f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5}));
            7'h13: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return f7 inside {7'h00, 7'h20};
                return 1'b1;
            end
            7'h37, 7'h17, 7'h6F: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Immediates rebuilt as signed integer offsets, then truncated to the port widths
    function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] p);
        dec_t        d;
        int          si;
        int          ss;
        int          sbr;
        int          sj;
        logic [31:0] t;
        si  = $signed(w) >>> 20;
        ss  = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
        sbr = (($signed(w) >>> 31) * 4096) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
              + int'(w[11:8]) * 2;
        sj  = (($signed(w) >>> 31) * 1048576) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
              + int'(w[30:21]) * 2;
        d.pc      = p;
        d.opcode  = w[6:0];
        d.rd      = w[11:7];
        d.funct3  = w[14:12];
        d.rs1     = w[19:15];
        d.rs2     = w[24:20];
        d.funct7  = w[31:25];
        d.imm_i   = 12'(si);
        d.imm_s   = 12'(ss);
        t         = sbr;
        d.imm_b   = t[12:1];
        d.imm_j   = 21'(sj);
        d.imm_u   = w[31:12];
        case (w[6:0])
            7'h13, 7'h03, 7'h67: d.imm32 = si;
            7'h23:               d.imm32 = ss;
            7'h63:               d.imm32 = sbr;
            7'h6F:               d.imm32 = sj;
            7'h37, 7'h17:        d.imm32 = w & 32'hFFFF_F000;
            7'h33:               d.imm32 = int'(w[24:20]);
            default:             d.imm32 = 32'd0;
        endcase
        d.illegal = !is_legal(w);
        return d;
    endfunction

    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        case (w[6:0])
            7'h33, 7'h23, 7'h63: return (w[19:15] == r) || (w[24:20] == r);
            7'h13, 7'h03, 7'h67: return w[19:15] == r;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h03;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h17;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h33;
            5: w[6:0] = 7'h37;
            6: w[6:0] = 7'h63;
            7: w[6:0] = 7'h67;
            8: w[6:0] = 7'h6F;
            default: w[6:0] = 7'($urandom());
        endcase
        // Narrow register numbers so load-use pairs occur often
        if ($urandom_range(0, 1) == 1) begin
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; the model advances at the rising edge
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                        input logic ordy, input logic fl, input logic rst);
        bit hz;
        bit rdy;
        @(negedge clk);
        in_valid  = v;
        in_instr  = w;
        in_pc     = p;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rst;
        hz  = rst && v && m_valid && (m_held[6:0] == 7'h03) && (m_held[11:7] != 5'd0)
              && reads_reg(w, m_held[11:7]);
        rdy = rst && !fl && !hz && (!m_valid || ordy);
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        @(posedge clk);
        if (!rst) begin
            sb.delete();
            m_valid = 1'b0;
            m_cnt   = 16'd0;
        end else begin
            if (fl) begin
                // A held entry not taken this cycle is discarded
                if (m_valid && !ordy && sb.size() > 0) void'(sb.pop_front());
                m_valid = 1'b0;
            end else if (v && rdy) begin
                sb.push_back(ref_decode(w, p));
                m_valid = 1'b1;
                m_held  = w;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (!fl && hz && ordy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    // Monitor: compares presented outputs with the scoreboard head
    initial begin
        dec_t act;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
                chk("bubble_count", {16'd0, bubble_count}, {16'd0, m_cnt});
                if (out_valid === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_empty out_valid=1 exp_entries=0");
                    end else begin
                        act = {pc, opcode, rd, funct3, rs1, rs2, funct7, imm_i, imm_s, imm_b,
                               imm_j, imm_u, imm32, illegal};
                        if (act !== sb[0]) begin
                            errors++;
                            $display("FAIL decode act=%h exp=%h", act, sb[0]);
                        end
                        if (out_ready) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    localparam logic [31:0] Addi   = 32'hFFF1_0093;
    localparam logic [31:0] Beq    = 32'hFE00_0EE3;
    localparam logic [31:0] Lui    = 32'h1234_51B7;
    localparam logic [31:0] Lw     = 32'h0000_A283;
    localparam logic [31:0] AddDep = 32'h0072_8333;
    localparam logic [31:0] AddInd = 32'h0072_0333;

    initial begin
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        chk("reset_bubbles", {16'd0, bubble_count}, 32'd0);
        chk("reset_imm32", imm32, 32'd0);
        chk("reset_pc", pc, 32'd0);
        mon_en = 1'b1;

        // Field extraction on known encodings
        step(1'b1, Addi, 32'h100, 1'b1, 1'b0, 1'b1);
        #1;
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_imm32", imm32, 32'hFFFF_FFFF);
        chk("addi_imm_i", {20'd0, imm_i}, 32'h0000_0FFF);
        chk("addi_regs", {17'd0, rd, rs1, funct3, 2'd0}, {17'd0, 5'd1, 5'd2, 3'd0, 2'd0});
        step(1'b1, Beq, 32'h104, 1'b1, 1'b0, 1'b1);
        #1;
        chk("beq_imm_b", {20'd0, imm_b}, 32'h0000_0FFE);
        chk("beq_imm32", imm32, 32'hFFFF_FFFC);
        step(1'b1, Lui, 32'h108, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lui_imm_u", {12'd0, imm_u}, 32'h0001_2345);
        chk("lui_imm32", imm32, 32'h1234_5000);

        // Load-use: one bubble, then an independent pair with none
        step(1'b1, Lw, 32'h10C, 1'b1, 1'b0, 1'b1);
        step(1'b1, AddDep, 32'h110, 1'b1, 1'b0, 1'b1);
        step(1'b1, AddDep, 32'h110, 1'b1, 1'b0, 1'b1);
        #1;
        chk("loaduse_bubbles", {16'd0, bubble_count}, 32'd1);
        step(1'b1, Lw, 32'h114, 1'b1, 1'b0, 1'b1);
        step(1'b1, AddInd, 32'h118, 1'b1, 1'b0, 1'b1);
        #1;
        chk("nodep_bubbles", {16'd0, bubble_count}, 32'd1);

        // Backpressure: three stalled cycles, then release
        for (int i = 0; i < 3; i++) step(1'b1, Addi, 32'h11C, 1'b0, 1'b0, 1'b1);
        step(1'b1, Addi, 32'h11C, 1'b1, 1'b0, 1'b1);
        #1;
        chk("release_pc", pc, 32'h11C);

        // Flush during a hazard empties the stage and counts nothing
        step(1'b1, Lw, 32'h120, 1'b1, 1'b0, 1'b1);
        step(1'b1, AddDep, 32'h124, 1'b1, 1'b1, 1'b1);
        #1;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_bubbles", {16'd0, bubble_count}, 32'd1);

        // Illegal encodings
        step(1'b1, 32'h0000_0000, 32'h200, 1'b1, 1'b0, 1'b1);
        #1;
        chk("illegal_zero", {31'd0, illegal}, 32'd1);
        step(1'b1, 32'h0000_B003, 32'h204, 1'b1, 1'b0, 1'b1);
        #1;
        chk("illegal_load_f3", {31'd0, illegal}, 32'd1);
        step(1'b1, 32'h4000_1033, 32'h208, 1'b1, 1'b0, 1'b1);
        #1;
        chk("illegal_rtype_f7", {31'd0, illegal}, 32'd1);

        // Reset in the middle of backpressure
        step(1'b1, Addi, 32'h20C, 1'b0, 1'b0, 1'b1);
        step(1'b1, Addi, 32'h20C, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_bp_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bp_bubbles", {16'd0, bubble_count}, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(), $urandom(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 149) != 0));
        end

        mon_en = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered instruction-decode stage that produces the field set the ALU consumes: opcode, rs1, rs2, rd, funct3, funct7, the per-format immediates and the selected imm32.
- Sits between fetch and execute and decouples them with valid/ready handshakes on both sides.
- Inserts one bubble on a load-use hazard, drops its contents on a branch/jump flush, and counts inserted bubbles.

Parameters:
- BUBBLE_CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  discard the held and incoming instruction (taken branch/jump).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts in_instr/in_pc this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  32  PC of in_instr.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  execute consumes the output this cycle.
- pc  out  32  registered PC.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- imm_i  out  12  instr[31:20].
- imm_s  out  12  {instr[31:25], instr[11:7]}.
- imm_b  out  12  imm[12:1] = {instr[31], instr[7], instr[30:25], instr[11:8]}.
- imm_j  out  21  {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- imm_u  out  20  instr[31:12].
- imm32  out  32  format-selected immediate (see Behaviour).
- illegal  out  1  instruction is not a supported RV32I encoding.
- bubble_count  out  BUBBLE_CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (rst_n=0 at an edge):
  - out_valid=0, illegal=0, bubble_count=0, and every field output is 0.
  - in_ready=0 combinationally while rst_n=0.
- Datapath and latency:
  - One output register stage; an accepted instruction appears on the outputs the next cycle.
  - Accept condition: in_valid & in_ready.
- Handshake:
  - in_ready = rst_n & ~flush & ~hazard & (~out_valid | out_ready).
  - While out_valid=1 and out_ready=0, every output holds stable.
  - out_valid can drop only through out_ready, flush or reset.
- Output register update at each edge, in priority order:
  - flush=1: out_valid<=0; the incoming instruction is dropped. Flush overrides hazard, handshake and acceptance.
  - Accept: load decoded fields; out_valid<=1.
  - out_ready=1 with no accept (including a hazard stall): out_valid<=0, i.e. a bubble.
  - Otherwise: hold.
- imm32 selection by opcode:
  - I-type 0010011, LOAD 0000011, JALR 1100111: sign-extended imm_i.
  - STORE 0100011: sign-extended imm_s.
  - BRANCH 1100011: sign-extended {imm_b, 1'b0}.
  - JAL 1101111: sign-extended imm_j.
  - LUI 0110111 and AUIPC 0010111: {imm_u, 12'b0}.
  - R-type 0110011: {27'b0, instr[24:20]}.
  - Anything else: 0.
- Register-source usage (for hazard detection):
  - R-type, STORE, BRANCH use rs1 and rs2.
  - I-type, LOAD, JALR use rs1 only.
  - LUI, AUIPC, JAL use none.
- Load-use hazard:
  - hazard = in_valid & out_valid & (held opcode == LOAD) & (held rd != 0) & (incoming uses rs1 or rs2, and that field equals held rd).
  - While hazard=1: in_ready=0.
  - When out_ready=1 the load leaves, out_valid goes to 0 (one bubble), and bubble_count increments if not saturated.
  - The hazard clears next cycle because out_valid=0.
  - Exactly one bubble per load-use pair.
  - Flush in the same cycle suppresses the increment.
- illegal=1 when any of the following holds:
  - Opcode is not one of the nine listed above.
  - LOAD funct3 is in {011, 110, 111}.
  - STORE funct3 > 010.
  - BRANCH funct3 is in {010, 011}.
  - JALR funct3 != 000.
  - R-type funct7 is not 0000000/0100000, or funct7=0100000 with funct3 not in {000, 101}.
  - I-type funct3=001 with funct7 != 0000000.
  - I-type funct3=101 with funct7 not 0000000/0100000.
- Illegal instructions still flow through with all fields decoded.
- Reset mid-stall or mid-backpressure: reset wins; the stage comes up empty.

Test Plan:
- addi x1,x2,-1 (0xFFF10093) with out_ready=1 -> next cycle: out_valid=1, opcode=0010011, rd=1, rs1=2, funct3=000, imm_i=0xFFF, imm32=0xFFFFFFFF, illegal=0.
- beq x0,x0,-4 (0xFE000EE3) -> imm_b=0xFFE, imm32=0xFFFFFFFC. lui x3,0x12345 (0x123451B7) -> imm_u=0x12345, imm32=0x12345000.
- lw x5,0(x1) (0x0000A283) followed by add x6,x5,x7 (0x00728333), out_ready=1 -> add is held one cycle (in_ready=0), one out_valid=0 cycle appears between them, bubble_count=1. Repeat with add x6,x4,x7 -> no bubble.
- out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> in_ready=0 and outputs stable. out_ready=1 -> next instruction appears one cycle later.
- flush=1 while out_valid=1 and in_valid=1 (also during a hazard) -> next cycle out_valid=0, incoming instruction lost, bubble_count unchanged.
- 0x00000000, 0x0000B003 (LOAD funct3=011), 0x40001033 (funct7=0100000, funct3=001) -> each gives illegal=1. Reset asserted mid-backpressure -> out_valid=0, bubble_count=0.
